// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants and types for vga_timing_gen and the
// downstream colour stage. Default geometry is 640x480@60 with a /4 pixel
// clock-enable and active-low syncs.
package vga_timing_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned COORD_LIMIT = 1024;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam bit          DEF_SYNC_POL = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  // Registered per-pixel payload presented to the colour stage.
  typedef struct packed {
    logic   ce;
    coord_t x;
    coord_t y;
    logic   valid;
    logic   hsync;
    logic   vsync;
    logic   line_start;
    logic   frame_start;
  } pix_timing_t;

  // Sync level for a counter that is / is not inside its sync window.
  function automatic logic sync_level(input logic in_window, input logic pol);
    return in_window ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus from vga_timing_gen (master) to the colour stage (slave).
// FRAME_CNT exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic   PIX_CE;
  coord_t PIX_X;
  coord_t PIX_Y;
  logic   PIX_VALID;
  logic   VGA_HSYNC;
  logic   VGA_VSYNC;
  logic   LINE_START;
  logic   FRAME_START;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] FRAME_CNT;
`endif

  modport master (
    output PIX_CE, output PIX_X, output PIX_Y, output PIX_VALID,
    output VGA_HSYNC, output VGA_VSYNC, output LINE_START, output FRAME_START
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output FRAME_CNT
`endif
  );

  modport slave (
    input PIX_CE, input PIX_X, input PIX_Y, input PIX_VALID,
    input VGA_HSYNC, input VGA_VSYNC, input LINE_START, input FRAME_START
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input FRAME_CNT
`endif
  );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Pixel clock-enable divider: CE is high for one CLK out of every DIV.
// Ports: CLK (clock), RST (sync active-high reset), CE (registered enable).
// CE is a registered look-ahead of the count, so it is high exactly in the
// cycle where the count sits at DIV-1; the first CE after reset therefore
// falls on the DIV-th edge that samples RST low.
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic CE
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("clk_en_div: DIV must be >= 1");
  end

  logic [CNT_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;

  // Next count and whether that count is the terminal one.
  always_comb begin
    div_d = (div_q == CNT_W'(DIV - 1)) ? '0 : div_q + CNT_W'(1);
    ce_d  = (div_d == CNT_W'(DIV - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
      ce_q  <= 1'(DIV == 1);
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  assign CE = ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters stepped by a pixel
// clock-enable, driving syncs, coordinates, active-video and line/frame
// strobes for the colour stage.
// Ports: CLK, RST (sync active-high), vga (vga_timing_if.master).
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit FRAME_CNT output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic         CLK,
  input  logic         RST,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC - 1;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC - 1;

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
  end

  logic        ce;
  coord_t      h_q, h_d, v_q, v_d;
  logic        h_wrap, v_wrap;
  pix_timing_t out_q, out_d;

  clk_en_div #(.DIV(CLK_DIV)) u_clk_en_div (
    .CLK (CLK),
    .RST (RST),
    .CE  (ce)
  );

  // Raster position; reset parks it on the last pixel so the first advance lands on (0,0).
  always_comb begin
    h_wrap = (h_q == COORD_W'(H_TOTAL - 1));
    v_wrap = (v_q == COORD_W'(V_TOTAL - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (ce) begin
      h_d = h_wrap ? '0 : h_q + COORD_W'(1);
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + COORD_W'(1);
      end
    end
  end

  // Output payload describes the new position; strobes last one cycle.
  always_comb begin
    out_d             = out_q;
    out_d.ce          = 1'b0;
    out_d.line_start  = 1'b0;
    out_d.frame_start = 1'b0;
    if (ce) begin
      out_d.ce          = 1'b1;
      out_d.x           = h_d;
      out_d.y           = v_d;
      out_d.valid       = (h_d < COORD_W'(H_ACTIVE)) && (v_d < COORD_W'(V_ACTIVE));
      out_d.hsync       = sync_level((h_d >= COORD_W'(HS_BEG)) && (h_d <= COORD_W'(HS_END)), SYNC_POL);
      // v only moves on the h wrap, so VSYNC edges line up with h=0.
      out_d.vsync       = sync_level((v_d >= COORD_W'(VS_BEG)) && (v_d <= COORD_W'(VS_END)), SYNC_POL);
      out_d.line_start  = (h_d == '0);
      out_d.frame_start = (h_d == '0) && (v_d == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_q   <= COORD_W'(H_TOTAL - 1);
      v_q   <= COORD_W'(V_TOTAL - 1);
      out_q <= '{ce: 1'b0, x: '0, y: '0, valid: 1'b0, hsync: ~SYNC_POL,
                 vsync: ~SYNC_POL, line_start: 1'b0, frame_start: 1'b0};
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      out_q <= out_d;
    end
  end

  assign vga.PIX_CE      = out_q.ce;
  assign vga.PIX_X       = out_q.x;
  assign vga.PIX_Y       = out_q.y;
  assign vga.PIX_VALID   = out_q.valid;
  assign vga.VGA_HSYNC   = out_q.hsync;
  assign vga.VGA_VSYNC   = out_q.vsync;
  assign vga.LINE_START  = out_q.line_start;
  assign vga.FRAME_START = out_q.frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts frames started since reset: 0 during the first frame, wraps at 16 bits.
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   seen_q, seen_d;

  always_comb begin
    fcnt_d = fcnt_q;
    seen_d = seen_q;
    if (out_d.frame_start) begin
      seen_d = 1'b1;
      if (seen_q) begin
        fcnt_d = fcnt_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt_q <= '0;
      seen_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      seen_q <= seen_d;
    end
  end

  assign vga.FRAME_CNT = fcnt_q;
`endif

endmodule
